adder_trio_16: RTL and testbench
================================

ADDER_TRIO_16 -- requirements
Module: adder_trio_16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width; legal values are multiples of BLOCK.
REQ-002 SHALL have parameter BLOCK, default 4, meaning adder group size for lookahead, select and skip blocks.
REQ-003 SHALL have one clock, with reset asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all registers.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ina  input  WIDTH  addend A.
REQ-007 inb  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in.
REQ-009 sum_cla  output  WIDTH  registered sum from the carry-lookahead datapath.
REQ-010 cout_cla  output  1  registered carry-out from the carry-lookahead datapath.
REQ-011 sum_csel  output  WIDTH  registered sum from the carry-select datapath.
REQ-012 cout_csel  output  1  registered carry-out from the carry-select datapath.
REQ-013 sum_cskip  output  WIDTH  registered sum from the carry-skip datapath.
REQ-014 cout_cskip  output  1  registered carry-out from the carry-skip datapath.
REQ-015 mismatch  output  1  registered flag, 1 when the three {cout,sum} results disagree.

Function
REQ-016 Every datapath SHALL compute {cout,sum} = ina + inb + cin, unsigned, exactly WIDTH+1 bits, no saturation; wrap-around goes into cout.
REQ-017 CLA: per bit g=a&b and p=a^b; per BLOCK group, lookahead carries from g/p; group G/P feed a second-level lookahead producing group carry-ins; no ripple between groups.
REQ-018 Carry-select: block 0 is a BLOCK-bit ripple adder fed by cin; every other block computes sums for carry-in 0 and 1 in parallel; the previous block's carry-out selects both sum and carry.
REQ-019 Carry-skip: each block is a BLOCK-bit ripple adder; block carry-out = (AND of the block's p bits) ? block carry-in : ripple carry-out.
REQ-020 Inputs SHALL be combinational into the three datapaths; all outputs SHALL be registered on the rising clk edge, so latency is exactly 1 cycle and throughput is 1 result per cycle.
REQ-021 mismatch SHALL be computed from the same-cycle combinational results and registered with them.
REQ-022 There is no handshake; a new operand set SHALL be accepted every cycle.
REQ-023 Full propagate case (every p=1) SHALL produce sum = ~cin replicated and cout = cin in all three datapaths.

Reset
REQ-024 While rst_n=0, all sum outputs, all cout outputs and mismatch SHALL be 0, asynchronously and regardless of clk.
REQ-025 The first rising clk after rst_n deasserts SHALL load the result of the operands present at that edge.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight result; no other state exists.

Structure
REQ-027 WIDTH and BLOCK defaults SHALL come from a shared package adder_pkg.
REQ-028 adder_pkg SHALL also hold the derived constant NBLK = WIDTH/BLOCK.
REQ-029 One sub-module ripple_block (BLOCK-bit ripple adder with p-AND output) SHALL be reused by the carry-select and carry-skip datapaths.
REQ-030 The CLA datapath SHALL be generate-based inline logic.

Verification
REQ-031 Scenario: rst_n=0 with ina=16'h1234 -> all outputs 0; after release, ina=0, inb=0, cin=0 -> sums 0x0000, couts 0, mismatch 0.
REQ-032 Scenario: ina=16'hAAAA, inb=16'h5555, cin=0 -> all sums 0xFFFF, couts 0, mismatch 0, one cycle later.
REQ-033 Scenario: same operands with cin=1 -> all sums 0x0000, couts 1 (full skip/lookahead propagation).
REQ-034 Scenario: ina=16'hFFFF, inb=16'h0001, cin=0 -> sums 0x0000, couts 1; ina=16'h7FFF, inb=16'h7FFF, cin=1 -> sums 0xFFFF, couts 0.
REQ-035 Scenario: 10k random operands with bits 15 and 14:0 randomised and random cin, one per cycle -> each output equals the behavioural ina+inb+cin from the prior cycle, and mismatch stays 0.
REQ-036 Scenario: assert rst_n between two clocks during the random stream -> outputs drop to 0 immediately, and the correct stream resumes one cycle after release.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared sizing constants for the adder_trio_16 slice.
//   WIDTH : default operand/sum width
//   BLOCK : default group size for the lookahead, select and skip blocks
//   NBLK  : number of groups for the default configuration
package adder_pkg;
  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NBLK  = WIDTH / BLOCK;
endpackage

// File: rtl/adder_trio_16_if.sv
// Operand/result bundle for adder_trio_16.
//   master : drives ina/inb/cin, observes the three registered results
//   slave  : the adder side (consumes operands, produces results)
interface adder_trio_16_if #(
  parameter int WIDTH = adder_pkg::WIDTH
);
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             cin;
  logic [WIDTH-1:0] sum_cla;
  logic             cout_cla;
  logic [WIDTH-1:0] sum_csel;
  logic             cout_csel;
  logic [WIDTH-1:0] sum_cskip;
  logic             cout_cskip;
  logic             mismatch;

  modport master (
    output ina, inb, cin,
    input  sum_cla, cout_cla, sum_csel, cout_csel, sum_cskip, cout_cskip, mismatch
  );

  modport slave (
    input  ina, inb, cin,
    output sum_cla, cout_cla, sum_csel, cout_csel, sum_cskip, cout_cskip, mismatch
  );
endinterface

// File: rtl/ripple_block.sv
// BLOCK-bit ripple-carry adder slice shared by the carry-select and
// carry-skip datapaths.
//   a, b  : addend slices
//   ci    : carry into the slice
//   s     : sum slice
//   co    : ripple carry-out
//   p_all : AND of the per-bit propagate terms (a^b)
module ripple_block #(
  parameter int BLOCK = adder_pkg::BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             p_all
);
  logic c;

  always_comb begin
    // NOTE: every variable written here gets a value on entry, so no latch
    // can be inferred; the carry is a blocking temporary that must update
    // in program order as it ripples through the loop.
    c = ci;
    s = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co    = c;
    p_all = &(a ^ b);
  end
endmodule

// File: rtl/adder_trio_16.sv
// Three structurally different adders computing {cout,sum} = ina+inb+cin
// side by side: two-level carry-lookahead, carry-select and carry-skip.
// All results plus a disagreement flag are registered (1-cycle latency,
// one operand set per cycle, no handshake).
//   clk, rst_n            : clock, asynchronous active-low reset
//   ina, inb, cin         : operands and carry-in
//   sum_*/cout_*          : registered result of each datapath
//   mismatch              : registered flag, 1 when the three results differ
module adder_trio_16 #(
  parameter int WIDTH = adder_pkg::WIDTH,
  parameter int BLOCK = adder_pkg::BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_cla,
  output logic             cout_cla,
  output logic [WIDTH-1:0] sum_csel,
  output logic             cout_csel,
  output logic [WIDTH-1:0] sum_cskip,
  output logic             cout_cskip,
  output logic             mismatch
);
  localparam int NBLK = WIDTH / BLOCK;

  // ---------------- carry-lookahead ----------------
  logic [WIDTH-1:0] g, p, cla_sum;
  logic [NBLK-1:0]  grp_g, grp_p;
  logic [NBLK:0]    grp_c;   // grp_c[k] = carry into group k

  assign g = ina & inb;
  assign p = ina ^ inb;

  for (genvar n = 0; n < NBLK; n++) begin : g_cla
    logic [BLOCK-1:0] gg, pp, cc;
    logic             acc, prod, g_out;

    assign gg = g[n*BLOCK +: BLOCK];
    assign pp = p[n*BLOCK +: BLOCK];

    // Each in-group carry is a flat sum of products of g/p and the group
    // carry-in, written out term by term rather than chained.
    always_comb begin
      cc    = '0;
      acc   = 1'b0;
      prod  = 1'b0;
      g_out = 1'b0;
      for (int j = 0; j < BLOCK; j++) begin
        acc = grp_c[n];
        for (int m = 0; m < j; m++) acc = acc & pp[m];
        for (int k = 0; k < j; k++) begin
          prod = gg[k];
          for (int m = k + 1; m < j; m++) prod = prod & pp[m];
          acc = acc | prod;
        end
        cc[j] = acc;
      end
      // Group generate: carry out of the group assuming carry-in 0.
      for (int k = 0; k < BLOCK; k++) begin
        prod = gg[k];
        for (int m = k + 1; m < BLOCK; m++) prod = prod & pp[m];
        g_out = g_out | prod;
      end
    end

    assign grp_g[n]                  = g_out;
    assign grp_p[n]                  = &pp;
    assign cla_sum[n*BLOCK +: BLOCK] = pp ^ cc;
  end

  // Second-level lookahead: group carry-ins straight from group G/P and cin.
  logic acc2, prod2;
  always_comb begin
    grp_c    = '0;
    grp_c[0] = cin;
    acc2     = 1'b0;
    prod2    = 1'b0;
    for (int gi = 1; gi <= NBLK; gi++) begin
      acc2 = cin;
      for (int gm = 0; gm < gi; gm++) acc2 = acc2 & grp_p[gm];
      for (int gk = 0; gk < gi; gk++) begin
        prod2 = grp_g[gk];
        for (int gm = gk + 1; gm < gi; gm++) prod2 = prod2 & grp_p[gm];
        acc2 = acc2 | prod2;
      end
      grp_c[gi] = acc2;
    end
  end

  // ---------------- carry-select ----------------
  logic [WIDTH-1:0] csel_sum;
  logic [NBLK:1]    csel_c;   // csel_c[k] = carry out of block k-1
  logic             csel_p0_unused;

  ripple_block #(.BLOCK(BLOCK)) u_csel0 (
    .a(ina[0 +: BLOCK]), .b(inb[0 +: BLOCK]), .ci(cin),
    .s(csel_sum[0 +: BLOCK]), .co(csel_c[1]), .p_all(csel_p0_unused)
  );

  for (genvar n = 1; n < NBLK; n++) begin : g_csel
    logic [BLOCK-1:0] s0, s1;
    logic             c0, c1;
    // Propagate flags are not needed on the select path.
    logic             p0_unused, p1_unused;

    ripple_block #(.BLOCK(BLOCK)) u_ci0 (
      .a(ina[n*BLOCK +: BLOCK]), .b(inb[n*BLOCK +: BLOCK]), .ci(1'b0),
      .s(s0), .co(c0), .p_all(p0_unused)
    );
    ripple_block #(.BLOCK(BLOCK)) u_ci1 (
      .a(ina[n*BLOCK +: BLOCK]), .b(inb[n*BLOCK +: BLOCK]), .ci(1'b1),
      .s(s1), .co(c1), .p_all(p1_unused)
    );

    assign csel_sum[n*BLOCK +: BLOCK] = csel_c[n] ? s1 : s0;
    assign csel_c[n+1]                = csel_c[n] ? c1 : c0;
  end

  // ---------------- carry-skip ----------------
  logic [WIDTH-1:0] skip_sum;
  logic [NBLK:0]    skip_c;

  assign skip_c[0] = cin;

  for (genvar n = 0; n < NBLK; n++) begin : g_skip
    logic rc, pa;
    ripple_block #(.BLOCK(BLOCK)) u_blk (
      .a(ina[n*BLOCK +: BLOCK]), .b(inb[n*BLOCK +: BLOCK]), .ci(skip_c[n]),
      .s(skip_sum[n*BLOCK +: BLOCK]), .co(rc), .p_all(pa)
    );
    // A fully propagating block passes its carry-in straight through.
    assign skip_c[n+1] = pa ? skip_c[n] : rc;
  end

  // ---------------- output registers ----------------
  logic [WIDTH:0] cla_d, csel_d, cskip_d, cla_q, csel_q, cskip_q;
  logic           mismatch_d, mismatch_q;

  always_comb begin
    cla_d      = {grp_c[NBLK], cla_sum};
    csel_d     = {csel_c[NBLK], csel_sum};
    cskip_d    = {skip_c[NBLK], skip_sum};
    mismatch_d = (cla_d != csel_d) || (cla_d != cskip_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      cla_q      <= '0;
      csel_q     <= '0;
      cskip_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      cla_q      <= cla_d;
      csel_q     <= csel_d;
      cskip_q    <= cskip_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign {cout_cla,   sum_cla}   = cla_q;
  assign {cout_csel,  sum_csel}  = csel_q;
  assign {cout_cskip, sum_cskip} = cskip_q;
  assign mismatch                = mismatch_q;
endmodule

// File: tb/tb_adder_trio_16.sv
// Self-checking bench for adder_trio_16: directed vector table, random
// stream against an arithmetic reference, and async reset corner cases.
module tb_adder_trio_16;
  logic clk;
  logic rst_n;

  adder_trio_16_if #(.WIDTH(16)) bus ();

  adder_trio_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ina       (bus.ina),
    .inb       (bus.inb),
    .cin       (bus.cin),
    .sum_cla   (bus.sum_cla),
    .cout_cla  (bus.cout_cla),
    .sum_csel  (bus.sum_csel),
    .cout_csel (bus.cout_csel),
    .sum_cskip (bus.sum_cskip),
    .cout_cskip(bus.cout_cskip),
    .mismatch  (bus.mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [16:0] exp, input logic mm_exp);
    check({name, "/cla"},   {bus.cout_cla,   bus.sum_cla},   exp);
    check({name, "/csel"},  {bus.cout_csel,  bus.sum_csel},  exp);
    check({name, "/cskip"}, {bus.cout_cskip, bus.sum_cskip}, exp);
    check({name, "/mismatch"}, {16'h0, bus.mismatch}, {16'h0, mm_exp});
  endtask

  // Apply operands on the falling edge; results are sampled 1ns after the
  // following rising edge.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic ci);
    @(negedge clk);
    bus.ina = a;
    bus.inb = b;
    bus.cin = ci;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic ci);
    int unsigned total;
    total = int'(a) + int'(b) + int'(ci);
    return total[16:0];
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] v;
    v[15]   = 1'($urandom_range(0, 1));
    v[14:0] = 15'($urandom);
    return v;
  endfunction

  initial begin
    logic [15:0] ra, rb;
    logic        rc;

    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 17'h00000, "zero"});
    vecs.push_back('{16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF, "prop_cin0"});
    vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 17'h10000, "prop_cin1"});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 17'h10000, "wrap"});
    vecs.push_back('{16'h7FFF, 16'h7FFF, 1'b1, 17'h0FFFF, "7fff_x2_c1"});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "max"});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 17'h10000, "msb_only"});
    vecs.push_back('{16'h000F, 16'h0001, 1'b0, 17'h00010, "grp0_carry"});
    vecs.push_back('{16'h00FF, 16'h0000, 1'b1, 17'h00100, "two_grp_prop"});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 17'h01000, "mixed_gen"});

    // Reset held low with live operands: every output must read 0.
    rst_n   = 1'b0;
    bus.ina = 16'h1234;
    bus.inb = 16'h4321;
    bus.cin = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("in_reset", 17'h0, 1'b0);

    // First edge after release loads the operands present at that edge.
    bus.ina = 16'h0000;
    bus.inb = 16'h0000;
    bus.cin = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    check_all("first_after_reset", 17'h0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].ci);
      check_all(vecs[i].name, vecs[i].exp, 1'b0);
    end

    // Random stream, one operand set per cycle.
    for (int i = 0; i < 10000; i++) begin
      ra = rnd16();
      rb = rnd16();
      rc = 1'($urandom_range(0, 1));
      step(ra, rb, rc);
      check_all("rand", ref_add(ra, rb, rc), 1'b0);

      // Mid-stream reset: outputs drop asynchronously between edges.
      if (i == 5000) begin
        step(16'hFFFF, 16'h1234, 1'b1);
        check_all("pre_reset", ref_add(16'hFFFF, 16'h1234, 1'b1), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 17'h0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_hold", 17'h0, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.ina = 16'hBEEF;
        bus.inb = 16'h4111;
        bus.cin = 1'b1;
        @(posedge clk);
        #1;
        check_all("resume", 17'h10001, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
